// File: rtl/fpu_fadd_sub_if.sv
// Operand/result bundle between the FPU issue logic and the add/sub core.
interface fpu_fadd_sub_if;
    logic        faddsub_en_i;
    logic        faddsub_sel_i;
    logic        faddsub_sign1_i;
    logic [7:0]  faddsub_exp1_i;
    logic [23:0] faddsub_scfnd1_i;
    logic        faddsub_sign2_i;
    logic [7:0]  faddsub_exp2_i;
    logic [23:0] faddsub_scfnd2_i;
    logic        faddsub_sign_o;
    logic [7:0]  faddsub_exp_o;
    logic [22:0] faddsub_frac_o;
    logic [2:0]  faddsub_grs_bit_o;
    logic        faddsub_ready_o;

    modport master (
        output faddsub_en_i, faddsub_sel_i,
        output faddsub_sign1_i, faddsub_exp1_i, faddsub_scfnd1_i,
        output faddsub_sign2_i, faddsub_exp2_i, faddsub_scfnd2_i,
        input  faddsub_sign_o, faddsub_exp_o, faddsub_frac_o,
        input  faddsub_grs_bit_o, faddsub_ready_o
    );

    modport slave (
        input  faddsub_en_i, faddsub_sel_i,
        input  faddsub_sign1_i, faddsub_exp1_i, faddsub_scfnd1_i,
        input  faddsub_sign2_i, faddsub_exp2_i, faddsub_scfnd2_i,
        output faddsub_sign_o, faddsub_exp_o, faddsub_frac_o,
        output faddsub_grs_bit_o, faddsub_ready_o
    );
endinterface

// File: rtl/fpu_fadd_sub.sv
// Multi-cycle single-precision add/subtract core. Produces an unrounded,
// normalised result with guard/round/sticky bits for the rounding stage.
module fpu_fadd_sub #(
    parameter int         OPERAND_WIDTH     = 32,
    parameter int         EXPONENT_WIDTH    = 8,
    parameter int         FRACTION_WIDTH    = 23,
    parameter int         SIGNIFICAND_WIDTH = FRACTION_WIDTH + 1,
    parameter logic [7:0] BIASING_CONSTANT  = 8'h7F
) (
    input  logic          fpu_clk,
    input  logic          fpu_rst,
    fpu_fadd_sub_if.slave bus
);
    localparam int EW = EXPONENT_WIDTH;
    localparam int FW = FRACTION_WIDTH;
    localparam int SW = SIGNIFICAND_WIDTH;
    localparam int AW = SW + 3;              // aligned field {sig, G, R, S}
    localparam int XW = EW + 2;              // signed internal exponent
    localparam int LW = $clog2(AW + 1);
    localparam logic [EW-1:0]        EXP_ONES   = {BIASING_CONSTANT[EW-2:0], 1'b1};
    localparam logic signed [XW-1:0] EXP_ONES_X = $signed({2'b00, EXP_ONES});
    localparam logic signed [XW-1:0] ONE_X      = $signed({{(XW-1){1'b0}}, 1'b1});
    localparam logic [EW-1:0]        ONE_E      = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]        AW_E       = EW'(AW);
    localparam logic [FW-1:0]        QNAN_FRAC  = {1'b1, {(FW-1){1'b0}}};

    if (OPERAND_WIDTH != 1 + EXPONENT_WIDTH + FRACTION_WIDTH) begin : g_bad_width
        $error("fpu_fadd_sub: OPERAND_WIDTH does not match exponent and fraction widths");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_ADDSUB = 3'd2,
        ST_NORM   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t               state_r, state_nxt_s;
    logic                 cap_en_s, align_en_s, add_en_s, norm_en_s, out_en_s;
    logic                 sel_r, sign1_r, sign2_r;
    logic [EW-1:0]        exp1_r, exp2_r;
    logic [SW-1:0]        scfnd1_r, scfnd2_r;
    logic [SW-1:0]        a_sig_r;
    logic [AW-1:0]        b_al_r;
    logic signed [XW-1:0] exp_a_r;
    logic                 sign_r, eff_sub_r, spec_r, spec_nan_r, spec_sign_r;
    logic [AW:0]          sum_r;
    logic                 res_sign_r, out_sign_r, ready_r;
    logic [EW-1:0]        res_exp_r, out_exp_r;
    logic [FW-1:0]        res_frac_r, out_frac_r;
    logic [2:0]           res_grs_r, out_grs_r;

    logic [EW-1:0]        eexp1_s, eexp2_s, eexp_a_s, eexp_b_s, dist_s;
    logic [SW-1:0]        sig_a_s, sig_b_s;
    logic [AW-1:0]        b_field_s, b_shift_s, b_mask_s, b_al_s;
    logic                 swap_s, sign_s, eff_sub_s, spec_s, spec_nan_s, spec_sign_s;
    logic                 inf1_s, inf2_s, nan1_s, nan2_s;
    logic [AW:0]          a_ext_s, b_ext_s, sum_s;
    logic [LW-1:0]        lz_s;
    logic signed [XW-1:0] lz_x_s, limit_s, norm_exp_s;
    logic [XW-1:0]        shamt_s;
    logic [AW-1:0]        mant_s;
    logic                 n_sign_s;
    logic [EW-1:0]        n_exp_s;
    logic [FW-1:0]        n_frac_s;
    logic [2:0]           n_grs_s;

    // Leading-zero count of the pre-normalisation magnitude (priority encoder).
    function automatic logic [LW-1:0] lzc(input logic [AW-1:0] v);
        logic [LW-1:0] n;
        n = LW'(AW);
        for (int i = 0; i < AW; i++) begin
            if (v[i]) n = LW'(AW - 1 - i);
        end
        return n;
    endfunction

    // State register.
    always_ff @(posedge fpu_clk or posedge fpu_rst) begin
        if (fpu_rst) state_r <= ST_IDLE;
        else         state_r <= state_nxt_s;
    end

    // Next state: one step per edge while en is held, any drop of en aborts to IDLE.
    always_comb begin
        state_nxt_s = ST_IDLE;
        if (bus.faddsub_en_i) begin
            case (state_r)
                ST_IDLE:   state_nxt_s = ST_ALIGN;
                ST_ALIGN:  state_nxt_s = ST_ADDSUB;
                ST_ADDSUB: state_nxt_s = ST_NORM;
                ST_NORM:   state_nxt_s = ST_DONE;
                ST_DONE:   state_nxt_s = ST_DONE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // Stage load strobes decoded from the current state.
    always_comb begin
        cap_en_s   = 1'b0;
        align_en_s = 1'b0;
        add_en_s   = 1'b0;
        norm_en_s  = 1'b0;
        out_en_s   = 1'b0;
        if (bus.faddsub_en_i) begin
            case (state_r)
                ST_IDLE:   cap_en_s   = 1'b1;
                ST_ALIGN:  align_en_s = 1'b1;
                ST_ADDSUB: add_en_s   = 1'b1;
                ST_NORM:   norm_en_s  = 1'b1;
                ST_DONE:   out_en_s   = 1'b1;
                default:   cap_en_s   = 1'b0;
            endcase
        end else begin
            cap_en_s = 1'b0;
        end
    end

    // Operand capture; inputs are ignored once the operation has started.
    always_ff @(posedge fpu_clk or posedge fpu_rst) begin
        if (fpu_rst) begin
            sel_r    <= 1'b0;              sign1_r  <= 1'b0;            sign2_r <= 1'b0;
            exp1_r   <= {EW{1'b0}};        exp2_r   <= {EW{1'b0}};
            scfnd1_r <= {SW{1'b0}};        scfnd2_r <= {SW{1'b0}};
        end else if (cap_en_s) begin
            sel_r    <= bus.faddsub_sel_i;
            sign1_r  <= bus.faddsub_sign1_i;  sign2_r  <= bus.faddsub_sign2_i;
            exp1_r   <= bus.faddsub_exp1_i;   exp2_r   <= bus.faddsub_exp2_i;
            scfnd1_r <= bus.faddsub_scfnd1_i; scfnd2_r <= bus.faddsub_scfnd2_i;
        end
    end

    // Alignment: order by magnitude, shift the smaller operand, classify specials.
    always_comb begin
        if (exp1_r == {EW{1'b0}}) eexp1_s = ONE_E; else eexp1_s = exp1_r;
        if (exp2_r == {EW{1'b0}}) eexp2_s = ONE_E; else eexp2_s = exp2_r;
        swap_s = ({eexp2_s, scfnd2_r} > {eexp1_s, scfnd1_r});
        if (swap_s) begin
            eexp_a_s = eexp2_s; eexp_b_s = eexp1_s; sig_a_s = scfnd2_r; sig_b_s = scfnd1_r;
        end else begin
            eexp_a_s = eexp1_s; eexp_b_s = eexp2_s; sig_a_s = scfnd1_r; sig_b_s = scfnd2_r;
        end
        dist_s    = eexp_a_s - eexp_b_s;
        b_field_s = {sig_b_s, 3'b000};
        b_shift_s = {AW{1'b0}};
        b_mask_s  = {AW{1'b0}};
        if (dist_s >= AW_E) begin
            b_al_s = {{(AW-1){1'b0}}, |sig_b_s};
        end else begin
            b_shift_s = b_field_s >> dist_s;
            b_mask_s  = ~({AW{1'b1}} << dist_s);
            b_al_s    = {b_shift_s[AW-1:1], b_shift_s[0] | (|(b_field_s & b_mask_s))};
        end
        eff_sub_s  = sign1_r ^ sign2_r ^ sel_r;
        sign_s     = swap_s ? (sign2_r ^ sel_r) : sign1_r;
        inf1_s     = (exp1_r == EXP_ONES) && (scfnd1_r[FW-1:0] == {FW{1'b0}});
        inf2_s     = (exp2_r == EXP_ONES) && (scfnd2_r[FW-1:0] == {FW{1'b0}});
        nan1_s     = (exp1_r == EXP_ONES) && (scfnd1_r[FW-1:0] != {FW{1'b0}});
        nan2_s     = (exp2_r == EXP_ONES) && (scfnd2_r[FW-1:0] != {FW{1'b0}});
        spec_s     = (exp1_r == EXP_ONES) || (exp2_r == EXP_ONES);
        spec_nan_s = nan1_s | nan2_s | (inf1_s & inf2_s & eff_sub_s);
        if (spec_nan_s)               spec_sign_s = 1'b0;
        else if (exp1_r == EXP_ONES)  spec_sign_s = sign1_r;
        else                          spec_sign_s = sign2_r ^ sel_r;
    end

    // Alignment stage register.
    always_ff @(posedge fpu_clk or posedge fpu_rst) begin
        if (fpu_rst) begin
            a_sig_r <= {SW{1'b0}}; b_al_r <= {AW{1'b0}}; exp_a_r <= {XW{1'b0}};
            sign_r  <= 1'b0; eff_sub_r <= 1'b0; spec_r <= 1'b0;
            spec_nan_r <= 1'b0; spec_sign_r <= 1'b0;
        end else if (align_en_s) begin
            a_sig_r <= sig_a_s; b_al_r <= b_al_s; exp_a_r <= $signed({2'b00, eexp_a_s});
            sign_r  <= sign_s; eff_sub_r <= eff_sub_s; spec_r <= spec_s;
            spec_nan_r <= spec_nan_s; spec_sign_r <= spec_sign_s;
        end
    end

    // Magnitude add or subtract; A >= B so the difference never goes negative.
    always_comb begin
        a_ext_s = {1'b0, a_sig_r, 3'b000};
        b_ext_s = {1'b0, b_al_r};
        if (eff_sub_r) sum_s = a_ext_s - b_ext_s;
        else           sum_s = a_ext_s + b_ext_s;
    end

    // Add/subtract stage register.
    always_ff @(posedge fpu_clk or posedge fpu_rst) begin
        if (fpu_rst)       sum_r <= {(AW+1){1'b0}};
        else if (add_en_s) sum_r <= sum_s;
    end

    // Normalisation and final result selection (special > zero > overflow > finite).
    always_comb begin
        lz_s    = lzc(sum_r[AW-1:0]);
        lz_x_s  = $signed({{(XW-LW){1'b0}}, lz_s});
        limit_s = exp_a_r - ONE_X;
        shamt_s = {XW{1'b0}};
        if (sum_r[AW]) begin
            mant_s     = {sum_r[AW:2], sum_r[1] | sum_r[0]};
            norm_exp_s = exp_a_r + ONE_X;
        end else if (lz_x_s > limit_s) begin
            // Shift limited so the exponent bottoms out at the subnormal range.
            shamt_s    = limit_s;
            mant_s     = sum_r[AW-1:0] << shamt_s;
            norm_exp_s = {XW{1'b0}};
        end else begin
            shamt_s    = lz_x_s;
            mant_s     = sum_r[AW-1:0] << shamt_s;
            norm_exp_s = exp_a_r - lz_x_s;
        end
        if (spec_r) begin
            n_sign_s = spec_sign_r;
            n_exp_s  = EXP_ONES;
            n_frac_s = spec_nan_r ? QNAN_FRAC : {FW{1'b0}};
            n_grs_s  = 3'b000;
        end else if (sum_r == {(AW+1){1'b0}}) begin
            n_sign_s = 1'b0; n_exp_s = {EW{1'b0}}; n_frac_s = {FW{1'b0}}; n_grs_s = 3'b000;
        end else if (norm_exp_s >= EXP_ONES_X) begin
            n_sign_s = sign_r; n_exp_s = EXP_ONES; n_frac_s = {FW{1'b0}}; n_grs_s = 3'b000;
        end else begin
            n_sign_s = sign_r;
            n_exp_s  = mant_s[AW-1] ? norm_exp_s[EW-1:0] : {EW{1'b0}};
            n_frac_s = mant_s[AW-2:3];
            n_grs_s  = mant_s[2:0];
        end
    end

    // Normalisation stage register.
    always_ff @(posedge fpu_clk or posedge fpu_rst) begin
        if (fpu_rst) begin
            res_sign_r <= 1'b0; res_exp_r <= {EW{1'b0}};
            res_frac_r <= {FW{1'b0}}; res_grs_r <= 3'b000;
        end else if (norm_en_s) begin
            res_sign_r <= n_sign_s; res_exp_r <= n_exp_s;
            res_frac_r <= n_frac_s; res_grs_r <= n_grs_s;
        end
    end

    // Output registers: result published in DONE, held after an abort; ready tracks DONE.
    always_ff @(posedge fpu_clk or posedge fpu_rst) begin
        if (fpu_rst) begin
            out_sign_r <= 1'b0; out_exp_r <= {EW{1'b0}};
            out_frac_r <= {FW{1'b0}}; out_grs_r <= 3'b000; ready_r <= 1'b0;
        end else begin
            ready_r <= out_en_s;
            if (out_en_s) begin
                out_sign_r <= res_sign_r; out_exp_r <= res_exp_r;
                out_frac_r <= res_frac_r; out_grs_r <= res_grs_r;
            end
        end
    end

    assign bus.faddsub_sign_o    = out_sign_r;
    assign bus.faddsub_exp_o     = out_exp_r;
    assign bus.faddsub_frac_o    = out_frac_r;
    assign bus.faddsub_grs_bit_o = out_grs_r;
    assign bus.faddsub_ready_o   = ready_r;
endmodule

// File: tb/tb_fpu_fadd_sub.sv
// Directed self-checking bench for the single-precision add/sub core.
module tb_fpu_fadd_sub;
    logic fpu_clk;
    logic fpu_rst;
    int   n_checks;
    int   n_fail;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        sel;
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic [2:0]  grs;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    fpu_fadd_sub_if bus();

    fpu_fadd_sub dut (
        .fpu_clk (fpu_clk),
        .fpu_rst (fpu_rst),
        .bus     (bus)
    );

    initial begin
        fpu_clk = 1'b0;
        forever #5 fpu_clk = ~fpu_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic drive_op(input logic [31:0] op1, input logic [31:0] op2, input logic sel);
        bus.faddsub_sel_i    = sel;
        bus.faddsub_sign1_i  = op1[31];
        bus.faddsub_exp1_i   = op1[30:23];
        bus.faddsub_scfnd1_i = {|op1[30:23], op1[22:0]};
        bus.faddsub_sign2_i  = op2[31];
        bus.faddsub_exp2_i   = op2[30:23];
        bus.faddsub_scfnd2_i = {|op2[30:23], op2[22:0]};
        bus.faddsub_en_i     = 1'b1;
        @(posedge fpu_clk); #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge fpu_clk); #1;
            if (bus.faddsub_ready_o === 1'b1) begin
                n = i;
                break;
            end
        end
        check_eq({tag, "_latency"}, 40'(n), 40'd4);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check_eq({tag, "_sign"}, 40'(bus.faddsub_sign_o),    40'(v.sign));
        check_eq({tag, "_exp"},  40'(bus.faddsub_exp_o),     40'(v.exp));
        check_eq({tag, "_frac"}, 40'(bus.faddsub_frac_o),    40'(v.frac));
        check_eq({tag, "_grs"},  40'(bus.faddsub_grs_bit_o), 40'(v.grs));
    endtask

    task automatic end_op(input string tag);
        bus.faddsub_en_i = 1'b0;
        @(posedge fpu_clk); #1;
        check_eq({tag, "_ready_low"}, 40'(bus.faddsub_ready_o), 40'd0);
    endtask

    initial begin
        string tag;
        n_checks = 0;
        n_fail   = 0;
        vecs[0]  = '{{1'b1,8'h9B,23'h7D0E59}, {1'b1,8'h9B,23'h79E745}, 1'b0, 1'b1, 8'h9C, 23'h7B7ACF, 3'b000};
        vecs[1]  = '{{1'b0,8'h9B,23'h550A19}, {1'b0,8'h9A,23'h316745}, 1'b1, 1'b0, 8'h9A, 23'h78ACED, 3'b000};
        vecs[2]  = '{{1'b0,8'h00,23'h150E91}, {1'b0,8'h9A,23'h316745}, 1'b1, 1'b1, 8'h9A, 23'h316744, 3'b111};
        vecs[3]  = '{{1'b0,8'h80,23'h000000}, {1'b0,8'h80,23'h000000}, 1'b1, 1'b0, 8'h00, 23'h000000, 3'b000};
        vecs[4]  = '{{1'b0,8'h7F,23'h000000}, {1'b0,8'h80,23'h000000}, 1'b1, 1'b1, 8'h7F, 23'h000000, 3'b000};
        vecs[5]  = '{{1'b0,8'h9A,23'h000000}, {1'b0,8'h7F,23'h000000}, 1'b0, 1'b0, 8'h9A, 23'h000000, 3'b001};
        vecs[6]  = '{{1'b0,8'h01,23'h000001}, {1'b0,8'h01,23'h000000}, 1'b1, 1'b0, 8'h00, 23'h000001, 3'b000};
        vecs[7]  = '{{1'b0,8'h00,23'h400000}, {1'b0,8'h00,23'h400000}, 1'b0, 1'b0, 8'h01, 23'h000000, 3'b000};
        vecs[8]  = '{{1'b0,8'hFE,23'h7FFFFF}, {1'b0,8'hFE,23'h7FFFFF}, 1'b0, 1'b0, 8'hFF, 23'h000000, 3'b000};
        vecs[9]  = '{{1'b0,8'hFF,23'h000000}, {1'b0,8'h7F,23'h000000}, 1'b0, 1'b0, 8'hFF, 23'h000000, 3'b000};
        vecs[10] = '{{1'b1,8'hFF,23'h000000}, {1'b0,8'h80,23'h000000}, 1'b0, 1'b1, 8'hFF, 23'h000000, 3'b000};
        vecs[11] = '{{1'b0,8'hFF,23'h000000}, {1'b0,8'hFF,23'h000000}, 1'b1, 1'b0, 8'hFF, 23'h400000, 3'b000};
        vecs[12] = '{{1'b0,8'hFF,23'h000001}, {1'b0,8'h7F,23'h000000}, 1'b0, 1'b0, 8'hFF, 23'h400000, 3'b000};
        vecs[13] = '{{1'b0,8'h7F,23'h000000}, {1'b0,8'hFF,23'h000000}, 1'b1, 1'b1, 8'hFF, 23'h000000, 3'b000};

        bus.faddsub_en_i     = 1'b0;
        bus.faddsub_sel_i    = 1'b0;
        bus.faddsub_sign1_i  = 1'b0;
        bus.faddsub_exp1_i   = 8'h00;
        bus.faddsub_scfnd1_i = 24'h000000;
        bus.faddsub_sign2_i  = 1'b0;
        bus.faddsub_exp2_i   = 8'h00;
        bus.faddsub_scfnd2_i = 24'h000000;
        fpu_rst = 1'b1;
        #12;
        check_eq("rst_ready", 40'(bus.faddsub_ready_o), 40'd0);
        check_eq("rst_out", {5'b00000, bus.faddsub_sign_o, bus.faddsub_exp_o,
                             bus.faddsub_frac_o, bus.faddsub_grs_bit_o}, 40'd0);
        @(negedge fpu_clk);
        fpu_rst = 1'b0;

        // Directed vectors: nominal cases, alignment boundaries, subnormals, specials.
        for (int i = 0; i < NV; i++) begin
            tag = $sformatf("v%0d", i);
            drive_op(vecs[i].op1, vecs[i].op2, vecs[i].sel);
            wait_ready(tag);
            check_result(tag, vecs[i]);
            end_op(tag);
        end

        // Hold en in DONE: result and ready must stay put; then release.
        drive_op(vecs[1].op1, vecs[1].op2, vecs[1].sel);
        wait_ready("hold");
        for (int c = 0; c < 3; c++) begin
            @(posedge fpu_clk); #1;
            check_eq($sformatf("hold%0d_ready", c), 40'(bus.faddsub_ready_o), 40'd1);
            check_result($sformatf("hold%0d", c), vecs[1]);
        end
        end_op("hold");
        check_result("hold_keep", vecs[1]);

        // Abort in ADDSUB: ready never rises, previous result is kept.
        drive_op(vecs[0].op1, vecs[0].op2, vecs[0].sel);
        @(posedge fpu_clk); #1;
        bus.faddsub_en_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge fpu_clk); #1;
            check_eq($sformatf("abort%0d_ready", c), 40'(bus.faddsub_ready_o), 40'd0);
        end
        check_result("abort_keep", vecs[1]);

        // Asynchronous reset mid-operation clears outputs without waiting for an edge.
        drive_op(vecs[2].op1, vecs[2].op2, vecs[2].sel);
        @(posedge fpu_clk); #1;
        fpu_rst = 1'b1;
        #1;
        check_eq("midrst_ready", 40'(bus.faddsub_ready_o), 40'd0);
        check_eq("midrst_out", {5'b00000, bus.faddsub_sign_o, bus.faddsub_exp_o,
                                bus.faddsub_frac_o, bus.faddsub_grs_bit_o}, 40'd0);
        bus.faddsub_en_i = 1'b0;
        @(negedge fpu_clk);
        fpu_rst = 1'b0;
        @(posedge fpu_clk); #1;
        check_eq("postrst_ready", 40'(bus.faddsub_ready_o), 40'd0);

        // Operation after reset recovery.
        drive_op(vecs[2].op1, vecs[2].op2, vecs[2].sel);
        wait_ready("postrst");
        check_result("postrst", vecs[2]);
        end_op("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
